// File: rtl/symbol_packer.sv
// symbol_packer: assembles four 2-bit UART symbols MSB-first into a byte
// and queues completed bytes in a small first-word-fall-through FIFO.
module symbol_packer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 52080
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    sym_in,
  input  logic                          sym_valid,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_err,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [5:0]      r_asm;
  logic [TW-1:0]   r_tmo;
  logic            r_terr;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_oerr;

  logic            w_push;
  logic [7:0]      w_byte;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            w_expire;

  // Byte completes on the 4th symbol; the last symbol lands directly in [1:0]
  assign w_push   = sym_valid && (r_state == COLLECT) && (r_idx == 2'd3);
  assign w_byte   = {r_asm, sym_in};
  assign w_expire = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // FIFO handshake: a pop is only real when data is held
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = byte_ready && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_pop);

  assign byte_valid   = (r_count != '0);
  assign byte_out     = byte_valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count   = r_count;
  assign overflow_err = r_oerr;
  assign timeout_err  = r_terr;

  // Symbol collection FSM with idle timeout; a symbol always beats expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_asm   <= 6'd0;
      r_tmo   <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_terr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          if (sym_valid) begin
            r_asm   <= {sym_in, 4'b0000};
            r_idx   <= 2'd1;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (sym_valid) begin
            r_tmo <= '0;
            case (r_idx)
              2'd1: begin
                r_asm[3:2] <= sym_in;
                r_idx      <= 2'd2;
              end
              2'd2: begin
                r_asm[1:0] <= sym_in;
                r_idx      <= 2'd3;
              end
              default: begin
                r_asm   <= 6'd0;
                r_idx   <= 2'd0;
                r_state <= IDLE;
              end
            endcase
          end else if (w_expire) begin
            r_asm   <= 6'd0;
            r_idx   <= 2'd0;
            r_tmo   <= '0;
            r_terr  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Byte FIFO: simultaneous push and pop always both succeed, even when full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_oerr  <= 1'b0;
    end else begin
      r_oerr <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wptr] <= w_byte;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_symbol_packer.sv
// tb_symbol_packer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the packer.
module tb_symbol_packer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk;
  logic       rst;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic [2:0] fifo_count;
  logic       overflow_err;
  logic       timeout_err;

  symbol_packer #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sym_in(sym_in),
    .sym_valid(sym_valid),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .fifo_count(fifo_count),
    .overflow_err(overflow_err),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_q[$];
  int         m_n;
  int         m_acc;
  int         m_idle;
  int         terr_seen;
  int         oerr_seen;
  logic [7:0] last_popped;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_n = 0;
    m_acc = 0;
    m_idle = 0;
  endtask

  // one clock: drive, advance the model by the rules, compare all outputs
  task automatic cyc(input logic sv, input logic [1:0] s, input logic rdy);
    logic       pop;
    logic       done;
    logic [7:0] nb;
    logic       e_terr;
    logic       e_oerr;
    sym_valid  = sv;
    sym_in     = s;
    byte_ready = rdy;
    pop    = rdy && (m_q.size() > 0);
    done   = 1'b0;
    nb     = 8'h00;
    e_terr = 1'b0;
    e_oerr = 1'b0;
    if (sv) begin
      m_acc = m_acc * 4 + int'(s);
      m_n++;
      m_idle = 0;
      if (m_n == 4) begin
        done  = 1'b1;
        nb    = 8'(m_acc);
        m_n   = 0;
        m_acc = 0;
      end
    end else if (m_n > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_n = 0;
        m_acc = 0;
        m_idle = 0;
        e_terr = 1'b1;
      end
    end
    if (pop) last_popped = m_q.pop_front();
    if (done) begin
      if (m_q.size() < DEPTH) m_q.push_back(nb);
      else e_oerr = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("valid", byte_valid, m_q.size() > 0);
    chk("count", fifo_count, m_q.size());
    chk("byte", byte_out, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("terr", timeout_err, e_terr);
    chk("oerr", overflow_err, e_oerr);
    if (timeout_err) terr_seen++;
    if (overflow_err) oerr_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] t;
      t = b >> (2 * i);
      cyc(1'b1, t[1:0], rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_byte", byte_out, 8'h00);
    chk("rst_oerr", overflow_err, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int gap;
    rst        = 1'b1;
    sym_in     = 2'b00;
    sym_valid  = 1'b0;
    byte_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 00,01,10,11 -> 0x1B visible right after the 4th strobe
    cyc(1'b1, 2'b00, 1'b1);
    cyc(1'b1, 2'b01, 1'b1);
    cyc(1'b1, 2'b10, 1'b1);
    cyc(1'b1, 2'b11, 1'b1);
    chk("r1b_byte", byte_out, 8'h1B);
    chk("r1b_valid", byte_valid, 1'b1);
    idle(1, 1'b1);
    chk("r1b_drain", fifo_count, 3'd0);

    // five bytes into a 4-deep FIFO with no consumer
    oerr_seen = 0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h1B, 1'b0);
    chk("ovf_count", fifo_count, 3'd4);
    chk("ovf_pulses", oerr_seen, 1);
    idle(1, 1'b1);
    chk("drain0", last_popped, 8'h00);
    idle(1, 1'b1);
    chk("drain1", last_popped, 8'h55);
    idle(1, 1'b1);
    chk("drain2", last_popped, 8'hAA);
    idle(1, 1'b1);
    chk("drain3", last_popped, 8'hFF);
    idle(2, 1'b1);

    // partial byte abandoned after TMO idle clocks
    terr_seen = 0;
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    idle(TMO, 1'b0);
    chk("tmo_pulses", terr_seen, 1);
    send_byte(8'hE4, 1'b0);
    chk("tmo_next", byte_out, 8'hE4);
    idle(2, 1'b1);

    // symbol arriving on the expiring clock wins
    terr_seen = 0;
    cyc(1'b1, 2'b01, 1'b0);
    idle(TMO - 1, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    chk("race_terr", terr_seen, 0);
    chk("race_byte", byte_out, 8'h6C);
    idle(2, 1'b1);

    // full FIFO, pop coincides with completion of 0x33
    oerr_seen = 0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h88, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b11, 1'b1);
    chk("fullpp_count", fifo_count, 3'd4);
    chk("fullpp_oerr", oerr_seen, 0);
    idle(4, 1'b1);
    chk("fullpp_last", last_popped, 8'h33);
    idle(1, 1'b1);

    // reset mid-collection with data queued
    terr_seen = 0;
    oerr_seen = 0;
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    do_reset();
    send_byte(8'h55, 1'b0);
    chk("rstmid_byte", byte_out, 8'h55);
    chk("rstmid_count", fifo_count, 3'd1);
    chk("rstmid_err", terr_seen + oerr_seen, 0);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        gap = $urandom_range(10, 20);
        idle(gap, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), 2'($urandom),
            1'($urandom_range(0, 2) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
